// File: rtl/soc_bus_arbiter.sv
// Two-master data-bus arbiter: round-robin with M1 lock override, address decode to RAM/peripheral
// strobes, return-data mux and read-timeout protection. One transaction in flight at a time.
module soc_bus_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAM_ADDRW = 10,
  parameter int unsigned PERI_BASE = 32'h402,
  parameter int unsigned PERI_LAST = 32'h406,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [3:0]      m0_mode,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [3:0]      m1_mode,
  input  logic            m1_lock,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_rerr,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_rerr,
  output logic            dec_err,
  output logic            busy,
  output logic [XLEN-1:0] s_addr,
  output logic [XLEN-1:0] s_wdata,
  output logic [3:0]      s_mode,
  output logic            s_ram_wrEn,
  output logic            s_ram_rdEn,
  output logic            s_peri_wrEn,
  output logic            s_peri_rdEn,
  input  logic [XLEN-1:0] s_ram_rdata,
  input  logic [XLEN-1:0] s_uart_rdata,
  input  logic [XLEN-1:0] s_port_rdata,
  input  logic            s_ram_outEn,
  input  logic            s_uart_outEn,
  input  logic            s_port_outEn
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    RESP    = 3'd3,
    ERRRESP = 3'd4
  } state_t;

  function automatic logic isRam(input logic [XLEN-1:0] a);
    return (a[XLEN-1:RAM_ADDRW] == '0);
  endfunction

  function automatic logic isPeri(input logic [XLEN-1:0] a);
    return (a >= XLEN'(PERI_BASE)) && (a <= XLEN'(PERI_LAST));
  endfunction

  state_t          stateR;
  state_t          nextStateS;
  logic            rrPtrR;
  logic            winnerR;
  logic            weR;
  logic [CW-1:0]   cntR;

  logic            reqAnyS;
  logic            pickS;
  logic [XLEN-1:0] selAddrS;
  logic [XLEN-1:0] selWdataS;
  logic [3:0]      selModeS;
  logic            selWeS;
  logic            selRamS;
  logic            selPeriS;
  logic            launchS;
  logic            anyOutEnS;
  logic [XLEN-1:0] retDataS;
  logic            respS;
  logic            errRespS;
  logic [XLEN-1:0] respDataS;
  logic            respErrS;

  // Arbitration and request selection for the IDLE sample point.
  always_comb begin
    reqAnyS = m0_req | m1_req;
    pickS   = 1'b0;
    if (m1_lock && m1_req) begin
      pickS = 1'b1;
    end else if (m0_req && m1_req) begin
      pickS = rrPtrR;
    end else if (m1_req) begin
      pickS = 1'b1;
    end else begin
      pickS = 1'b0;
    end
    selAddrS  = pickS ? m1_addr  : m0_addr;
    selWdataS = pickS ? m1_wdata : m0_wdata;
    selModeS  = pickS ? m1_mode  : m0_mode;
    selWeS    = pickS ? m1_we    : m0_we;
    selRamS   = isRam(selAddrS);
    selPeriS  = isPeri(selAddrS) & ~selRamS;
    launchS   = (stateR == IDLE) && reqAnyS;
  end

  // Slave return mux, RAM > UART > PORT.
  always_comb begin
    anyOutEnS = s_ram_outEn | s_uart_outEn | s_port_outEn;
    if (s_ram_outEn) begin
      retDataS = s_ram_rdata;
    end else if (s_uart_outEn) begin
      retDataS = s_uart_rdata;
    end else if (s_port_outEn) begin
      retDataS = s_port_rdata;
    end else begin
      retDataS = '0;
    end
  end

  // Next-state logic and response qualifiers.
  always_comb begin
    nextStateS = stateR;
    respS      = 1'b0;
    errRespS   = 1'b0;
    case (stateR)
      IDLE: begin
        if (reqAnyS) nextStateS = ISSUE;
        else         nextStateS = IDLE;
      end
      ISSUE: begin
        if (weR) begin
          nextStateS = IDLE;
        end else if (dec_err) begin
          nextStateS = ERRRESP;
          errRespS   = 1'b1;
        end else begin
          nextStateS = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (anyOutEnS || (cntR == CW'(TIMEOUT))) begin
          nextStateS = RESP;
          respS      = 1'b1;
        end else begin
          nextStateS = WAIT_RD;
        end
      end
      RESP:    nextStateS = IDLE;
      ERRRESP: nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
    respDataS = errRespS ? '0 : retDataS;
    respErrS  = errRespS | ~anyOutEnS;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateR <= IDLE;
    else     stateR <= nextStateS;
  end

  // Transaction context: latched request, winner, rr pointer and read-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_addr  <= '0;
      s_wdata <= '0;
      s_mode  <= 4'b0000;
      weR     <= 1'b0;
      winnerR <= 1'b0;
      rrPtrR  <= 1'b0;
      cntR    <= '0;
    end else begin
      if (launchS) begin
        s_addr  <= selAddrS;
        s_wdata <= selWdataS;
        s_mode  <= selModeS;
        weR     <= selWeS;
        winnerR <= pickS;
      end
      if (stateR == ISSUE) begin
        rrPtrR <= ~winnerR;
        cntR   <= CW'(1);
      end else if ((stateR == WAIT_RD) && (cntR != CW'(TIMEOUT))) begin
        cntR <= cntR + CW'(1);
      end
    end
  end

  // Registered handshake, strobe and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      m0_rerr     <= 1'b0;
      m1_rerr     <= 1'b0;
      dec_err     <= 1'b0;
      busy        <= 1'b0;
      s_ram_wrEn  <= 1'b0;
      s_ram_rdEn  <= 1'b0;
      s_peri_wrEn <= 1'b0;
      s_peri_rdEn <= 1'b0;
    end else begin
      m0_gnt      <= launchS & ~pickS;
      m1_gnt      <= launchS & pickS;
      s_ram_wrEn  <= launchS & selRamS & selWeS;
      s_ram_rdEn  <= launchS & selRamS & ~selWeS;
      s_peri_wrEn <= launchS & selPeriS & selWeS;
      s_peri_rdEn <= launchS & selPeriS & ~selWeS;
      dec_err     <= launchS & ~selRamS & ~selPeriS;
      busy        <= (nextStateS != IDLE);
      m0_rvalid   <= (respS | errRespS) & ~winnerR;
      m1_rvalid   <= (respS | errRespS) & winnerR;
      if ((respS | errRespS) && !winnerR) begin
        m0_rdata <= respDataS;
        m0_rerr  <= respErrS;
      end
      if ((respS | errRespS) && winnerR) begin
        m1_rdata <= respDataS;
        m1_rerr  <= respErrS;
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed, table-driven bench for soc_bus_arbiter plus sequences for round-robin, lock and reset.
module tb_soc_bus_arbiter;

  localparam logic [31:0] RAM_D  = 32'hAAAA_0001;
  localparam logic [31:0] UART_D = 32'h0000_0041;
  localparam logic [31:0] PORT_D = 32'h5555_00F0;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_mode, m1_mode;
  logic        m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dec_err, busy;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_mode;
  logic        s_ram_wrEn, s_ram_rdEn, s_peri_wrEn, s_peri_rdEn;
  logic [31:0] s_ram_rdata, s_uart_rdata, s_port_rdata;
  logic        s_ram_outEn, s_uart_outEn, s_port_outEn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  soc_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mode(m0_mode),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mode(m1_mode),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .dec_err(dec_err), .busy(busy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_mode(s_mode),
    .s_ram_wrEn(s_ram_wrEn), .s_ram_rdEn(s_ram_rdEn),
    .s_peri_wrEn(s_peri_wrEn), .s_peri_rdEn(s_peri_rdEn),
    .s_ram_rdata(s_ram_rdata), .s_uart_rdata(s_uart_rdata), .s_port_rdata(s_port_rdata),
    .s_ram_outEn(s_ram_outEn), .s_uart_outEn(s_uart_outEn), .s_port_outEn(s_port_outEn)
  );

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mode;
    logic [2:0]  oen;    // {port,uart,ram} outEn pulse
    int          dly;    // WAIT_RD cycle (1-based) carrying the pulse
    logic        eRam;
    logic        ePeri;
    logic        eDec;
    int          eLat;   // cycles from gnt to rvalid (reads)
    logic [31:0] eData;
    logic        eErr;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    string tag;
    int    lat;
    int    other;
    tag = $sformatf("v%0d", idx);
    if (v.mst) begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_mode = v.mode;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_mode = v.mode;
    end
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk({tag, " gnt"}, {m1_gnt, m0_gnt}, v.mst ? 2'b10 : 2'b01);
    chk({tag, " ramStb"}, {s_ram_wrEn, s_ram_rdEn}, v.eRam ? (v.we ? 2'b10 : 2'b01) : 2'b00);
    chk({tag, " periStb"}, {s_peri_wrEn, s_peri_rdEn}, v.ePeri ? (v.we ? 2'b10 : 2'b01) : 2'b00);
    chk({tag, " dec_err"}, dec_err, v.eDec);
    chk({tag, " s_addr"}, s_addr, v.addr);
    chk({tag, " s_wdata"}, s_wdata, v.wdata);
    chk({tag, " s_mode"}, s_mode, v.mode);
    chk({tag, " busyIssue"}, busy, 1'b1);
    if (v.we) begin
      step();
      chk({tag, " busyAfterWr"}, busy, 1'b0);
      chk({tag, " strobesOff"}, {s_ram_wrEn, s_ram_rdEn, s_peri_wrEn, s_peri_rdEn, dec_err}, 5'b0);
    end else begin
      lat   = 0;
      other = 0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
        if (c == v.dly + 1) {s_port_outEn, s_uart_outEn, s_ram_outEn} = v.oen;
        step();
        {s_port_outEn, s_uart_outEn, s_ram_outEn} = 3'b000;
        if (v.mst ? m0_rvalid : m1_rvalid) other++;
        if (v.mst ? m1_rvalid : m0_rvalid) lat = c;
      end
      chk({tag, " rvalidLatency"}, lat, v.eLat);
      chk({tag, " rdata"}, v.mst ? m1_rdata : m0_rdata, v.eData);
      chk({tag, " rerr"}, v.mst ? m1_rerr : m0_rerr, v.eErr);
      chk({tag, " otherRvalid"}, other, 0);
      step();
      chk({tag, " rvalidPulse"}, {m1_rvalid, m0_rvalid}, 2'b00);
      chk({tag, " busyAfterRd"}, busy, 1'b0);
      chk({tag, " rdataHold"}, v.mst ? m1_rdata : m0_rdata, v.eData);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq;
    int got;
    int both;
    int lastCyc;
    int extra;

    vt[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'b0010, 3'b000, 0,  1'b1, 1'b0, 1'b0, 0,  32'h0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 32'h404, 32'h12345678, 4'b1000, 3'b000, 0,  1'b0, 1'b1, 1'b0, 0,  32'h0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h800, 32'h0000CAFE, 4'b0010, 3'b000, 0,  1'b0, 1'b0, 1'b1, 0,  32'h0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 32'h402, 32'h0,        4'b0010, 3'b010, 3,  1'b0, 1'b1, 1'b0, 4,  UART_D, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 32'h402, 32'h0,        4'b0010, 3'b000, 0,  1'b0, 1'b1, 1'b0, 16, 32'h0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 32'h800, 32'h0,        4'b0010, 3'b000, 0,  1'b0, 1'b0, 1'b1, 1,  32'h0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        4'b0010, 3'b111, 1,  1'b1, 1'b0, 1'b0, 2,  RAM_D, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 32'h406, 32'h0,        4'b0100, 3'b110, 2,  1'b0, 1'b1, 1'b0, 3,  UART_D, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 32'h401, 32'h0,        4'b0010, 3'b000, 0,  1'b0, 1'b0, 1'b1, 1,  32'h0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 32'h406, 32'h0,        4'b0011, 3'b100, 15, 1'b0, 1'b1, 1'b0, 16, PORT_D, 1'b0};
    vt[10] = '{1'b0, 1'b1, 32'h407, 32'h00000055, 4'b1000, 3'b000, 0,  1'b0, 1'b0, 1'b1, 0,  32'h0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 32'h0,   32'h0,        4'b0010, 3'b001, 1,  1'b1, 1'b0, 1'b0, 2,  RAM_D, 1'b0};

    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_mode = 4'b0000;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_mode = 4'b0000;
    m1_lock = 1'b0;
    s_ram_rdata = RAM_D; s_uart_rdata = UART_D; s_port_rdata = PORT_D;
    s_ram_outEn = 1'b0; s_uart_outEn = 1'b0; s_port_outEn = 1'b0;
    #12;
    chk("reset ctl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr, dec_err, busy,
                      s_ram_wrEn, s_ram_rdEn, s_peri_wrEn, s_peri_rdEn}, 12'b0);
    chk("reset s_addr", s_addr, 32'h0);
    chk("reset rdata", m0_rdata | m1_rdata | s_wdata, 32'h0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      runVec(vt[i], i);
    end

    // Both masters hold requests: strict alternation starting at M0.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h24; m1_wdata = 32'h2;
    seq = 4'b0000; got = 0; both = 0; lastCyc = 0;
    for (int c = 1; c <= 20 && got < 4; c++) begin
      step();
      if (m0_gnt && m1_gnt) both++;
      if (m0_gnt || m1_gnt) begin
        seq[got] = m1_gnt;
        got++;
        lastCyc = c;
        if (got == 4) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
        end
      end
    end
    chk("rr order", seq, 4'b1010);
    chk("rr grants", got, 4);
    chk("rr rate", lastCyc, 7);
    chk("rr both", both, 0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (m0_gnt || m1_gnt) extra++;
    end
    chk("rr no extra gnt", extra, 0);

    // Lock: M1 wins every arbitration even though rr points at M0.
    m1_lock = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    seq = 4'b0000; got = 0;
    for (int c = 1; c <= 20 && got < 3; c++) begin
      step();
      if (m0_gnt || m1_gnt) begin
        seq[got] = m1_gnt;
        got++;
        if (got == 3) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
          m1_lock = 1'b0;
        end
      end
    end
    chk("lock order", seq[2:0], 3'b111);
    step();
    step();

    // Reset asserted while a read waits for its slave.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_mode = 4'b0010;
    step();
    m0_req = 1'b0;
    chk("rstSeq gnt", m0_gnt, 1'b1);
    step();
    step();
    chk("rstSeq busyWait", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstSeq ctl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr, dec_err, busy,
                       s_ram_wrEn, s_ram_rdEn, s_peri_wrEn, s_peri_rdEn}, 12'b0);
    chk("rstSeq s_addr", s_addr, 32'h0);
    chk("rstSeq s_mode", s_mode, 4'b0000);
    chk("rstSeq rdata", m0_rdata | m1_rdata | s_wdata, 32'h0);
    step();
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (m0_rvalid || m1_rvalid || m0_gnt || m1_gnt || busy) extra++;
    end
    chk("rstSeq no activity", extra, 0);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h404; m0_wdata = 32'h77;
    step();
    m0_req = 1'b0;
    chk("postRst gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("postRst periWr", s_peri_wrEn, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
